sram_scan16: RTL and testbench

Sequential scanner downstream of the 16×32 register-file memory. It consumes the flat 512-bit `mem` bus. On a `start` request it walks all 16 words, one per cycle, and reports the maximum word and its index. An optional running sum can be compiled in. Results are registered and held until the next scan completes, for use by control logic reading memory statistics.

---
 rtl/scan_pkg.sv | 19 +
 rtl/word_sel16.sv | 18 +
 rtl/sram_scan16.sv | 131 +++++++++++++
 tb/tb_sram_scan16.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and sizing constants for the sram_scan16 scanner.
// Sum support in the top is compiled in with the SCAN_SUM_EN macro.
package scan_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Memory geometry seen by the scanner
    localparam int SCAN_DEPTH = 16;
    localparam int SCAN_WIDTH = 32;

    // Sum of 16 words of 32 bits needs 4 extra bits and can never overflow
    localparam int SCAN_SUM_W = 36;

endpackage

// File: rtl/word_sel16.sv
// word_sel16: combinational 16:1 word mux over the flat memory image.
// Word i occupies bits [WIDTH*i +: WIDTH] of the bus.
module word_sel16
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH
) (
    input  logic [SCAN_DEPTH*WIDTH-1:0] mem,
    input  logic [3:0]                  idx,
    output logic [WIDTH-1:0]            word
);

    // Pick the addressed word out of the flat bus
    always_comb begin
        word = mem[idx*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/sram_scan16.sv
// sram_scan16: sequential max/index scanner over a 16-word flat memory bus.
// On start it visits one word per cycle (read live from mem), then pulses
// done and presents the maximum word and its lowest index. Defining
// SCAN_SUM_EN adds a running 36-bit sum and the sum output port.
module sram_scan16
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH,
    parameter int DEPTH = SCAN_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DEPTH*WIDTH-1:0] mem,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       max_val,
`ifdef SCAN_SUM_EN
    output logic [SCAN_SUM_W-1:0]  sum,
`endif
    output logic [3:0]             max_idx
);

    localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

    scan_state_t      state;
    logic [3:0]       idx;
    logic [WIDTH-1:0] acc_max;
    logic [3:0]       acc_idx;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] nxt_max;
    logic [3:0]       nxt_idx;

`ifdef SCAN_SUM_EN
    logic [SCAN_SUM_W-1:0] acc_sum;
    logic [SCAN_SUM_W-1:0] nxt_sum;
`endif

    word_sel16 #(
        .WIDTH (WIDTH)
    ) u_sel (
        .mem  (mem),
        .idx  (idx),
        .word (word)
    );

    // Next accumulator values; strict compare keeps the lowest index on ties
    always_comb begin
        nxt_max = acc_max;
        nxt_idx = acc_idx;
        if (word > acc_max) begin
            nxt_max = word;
            nxt_idx = idx;
        end
`ifdef SCAN_SUM_EN
        nxt_sum = acc_sum + {{(SCAN_SUM_W-WIDTH){1'b0}}, word};
`endif
    end

    // FSM, accumulators and registered result/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            acc_max <= '0;
            acc_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            max_val <= '0;
            max_idx <= '0;
`ifdef SCAN_SUM_EN
            acc_sum <= '0;
            sum     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        idx     <= '0;
                        acc_max <= '0;
                        acc_idx <= '0;
`ifdef SCAN_SUM_EN
                        acc_sum <= '0;
`endif
                    end
                end
                SCAN: begin
                    acc_max <= nxt_max;
                    acc_idx <= nxt_idx;
`ifdef SCAN_SUM_EN
                    acc_sum <= nxt_sum;
`endif
                    idx <= idx + 4'd1;
                    // Results are loaded from the next-values so the last word counts
                    if (idx == LAST_IDX) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        max_val <= nxt_max;
                        max_idx <= nxt_idx;
`ifdef SCAN_SUM_EN
                        sum     <= nxt_sum;
`endif
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        idx     <= '0;
                        acc_max <= '0;
                        acc_idx <= '0;
`ifdef SCAN_SUM_EN
                        acc_sum <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_scan16.sv
// tb_sram_scan16: directed self-checking bench for sram_scan16.
// Sum checks are active when SCAN_SUM_EN is defined.
module tb_sram_scan16;
    import scan_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] mem;
    logic         busy;
    logic         done;
    logic [31:0]  max_val;
    logic [3:0]   max_idx;
`ifdef SCAN_SUM_EN
    logic [35:0]  sum;
`endif

    int nchecks;
    int nerrors;

    logic [31:0] prev_max;
    logic [3:0]  prev_idx;
    logic [35:0] prev_sum;

    sram_scan16 #(
        .WIDTH (32),
        .DEPTH (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mem     (mem),
        .busy    (busy),
        .done    (done),
        .max_val (max_val),
`ifdef SCAN_SUM_EN
        .sum     (sum),
`endif
        .max_idx (max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [31:0] emax,
                                 input logic [3:0] eidx, input logic [35:0] esum);
        check({tag, ".max_val"}, 64'(max_val), 64'(emax));
        check({tag, ".max_idx"}, 64'(max_idx), 64'(eidx));
`ifdef SCAN_SUM_EN
        check({tag, ".sum"}, 64'(sum), 64'(esum));
`else
        if (esum == 36'h1) $display("note: unused sum");
`endif
    endtask

    // Start pulse, then check 16 busy cycles with held outputs, done at cycle 17
    task automatic run_scan(input string tag, input logic [31:0] emax,
                            input logic [3:0] eidx, input logic [35:0] esum);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check({tag, ".busy"}, 64'(busy), 64'd1);
            check({tag, ".nodone"}, 64'(done), 64'd0);
            if (c == 1 || c == 16) check_results({tag, ".hold"}, prev_max, prev_idx, prev_sum);
            @(negedge clk);
        end
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".busy_off"}, 64'(busy), 64'd0);
        check_results(tag, emax, eidx, esum);
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
        prev_max = emax;
        prev_idx = eidx;
        prev_sum = esum;
    endtask

    initial begin
        nchecks  = 0;
        nerrors  = 0;
        prev_max = '0;
        prev_idx = '0;
        prev_sum = '0;
        reset    = 1'b1;
        start    = 1'b0;
        mem      = '0;

        // Reset then idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle.busy", 64'(busy), 64'd0);
            check("idle.done", 64'(done), 64'd0);
        end
        check_results("reset", 32'd0, 4'd0, 36'd0);

        // Ramp: word i = i+1
        for (int unsigned i = 0; i < 16; i++) mem[32*i +: 32] = 32'(i + 1);
        run_scan("ramp", 32'd16, 4'd15, 36'd136);

        // Tie between words 3 and 9
        mem = '0;
        mem[32*3 +: 32] = 32'hFFFF_FFFF;
        mem[32*9 +: 32] = 32'hFFFF_FFFF;
        run_scan("tie", 32'hFFFF_FFFF, 4'd3, 36'h1_FFFF_FFFE);

        // All ones
        mem = '1;
        run_scan("ones", 32'hFFFF_FFFF, 4'd0, 36'hF_FFFF_FFF0);

        // Reset in scan cycle 8 aborts
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check_results("abort", 32'd0, 4'd0, 36'd0);
        prev_max = '0;
        prev_idx = '0;
        prev_sum = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("abort.nodone", 64'(done | busy), 64'd0);
        end

        // Fresh scan after abort: word i = 3*i, word 7 = 0xABCD
        for (int unsigned i = 0; i < 16; i++) mem[32*i +: 32] = 32'(3 * i);
        mem[32*7 +: 32] = 32'h0000_ABCD;
        run_scan("post_abort", 32'h0000_ABCD, 4'd7, 36'd44320);

        // Start held high: done every 17 cycles, never with busy
        for (int unsigned i = 0; i < 16; i++) mem[32*i +: 32] = 32'(i + 1);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            check("held.done", 64'(done), 64'((c % 17) == 0));
            check("held.busy", 64'(busy), 64'((c % 17) != 0));
            if (c == 51) start = 1'b0;
        end
        check_results("held", 32'd16, 4'd15, 36'd136);
        @(negedge clk);
        check("held.stop", 64'(busy | done), 64'd0);
        prev_max = 32'd16;
        prev_idx = 4'd15;
        prev_sum = 36'd136;

        // Word 0 changed after scan cycle 0; start pulses mid-scan ignored
        for (int unsigned i = 0; i < 16; i++) mem[32*i +: 32] = 32'(i + 1);
        mem[31:0] = 32'h50;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) mem[31:0] = 32'h1;
            start = (c >= 3 && c <= 5);
            check("mid.busy", 64'(busy), 64'd1);
            check("mid.nodone", 64'(done), 64'd0);
            @(negedge clk);
        end
        start = 1'b0;
        check("mid.done", 64'(done), 64'd1);
        check_results("mid", 32'h50, 4'd0, 36'd215);
        @(negedge clk);
        check("mid.idle", 64'(busy | done), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
